wombat: RTL and testbench
=========================

WOMBAT -- requirements
Module: wombat

Interface
REQ-001 Parameter ETHERTYPE, default 16'h88B5, EtherType that marks a trigger packet.
REQ-002 Parameter CF_LATENCY, default 4, compute-function latency in cycles; legal range 1..15.
REQ-003 axis_aclk  in  1  the only clock; all logic, including AXI-Lite, runs on it.
REQ-004 axis_reset  in  1  reset, asynchronous, active-high.
REQ-005 s_axis_tdata/tkeep/tuser/tvalid/tready/tlast  in,in,in,in,out,in  256/32/128/1/1/1  ingress AXI-Stream; byte n is tdata[8n+7:8n].
REQ-006 m_axis_tdata/tkeep/tuser/tvalid/tready/tlast  out,out,out,out,in,out  256/32/128/1/1/1  egress AXI-Stream.
REQ-007 S_AXI_* AXI4-Lite slave ports  mixed  12-bit address, 32-bit data  status registers.
REQ-008 S_AXI_ACLK and S_AXI_ARESETN  in  1 each  present for port compatibility and ignored.

Function
REQ-009 A packet is a trigger packet when all of the following hold on its first beat:
- tkeep[17:0] all ones;
- byte12 equals ETHERTYPE[15:8];
- byte13 equals ETHERTYPE[7:0].
REQ-010 Every other packet SHALL pass unchanged (data, keep, user, last) through one output register stage, with latency 1 cycle.
REQ-011 Output register SHALL load when empty or when m_axis_tready is high; s_axis_tready = (state is IDLE or PASS) and (!m_axis_tvalid or m_axis_tready).
REQ-012 Beats SHALL never be lost or duplicated under any m_axis_tready pattern.
REQ-013 FSM states and transitions:
- IDLE: on accepting a non-trigger first beat with tlast low, go to PASS; on a trigger first beat, go to CALC.
- PASS: on accepting tlast, go to IDLE.
- CALC: hold the first beat; s_axis_tready low.
- EMIT: load the modified beat, then go to PASS, or to IDLE if the held beat had tlast.
REQ-014 When a trigger beat is accepted, user_value = {byte14,byte15,byte16,byte17} (big-endian) and user_value_valid pulses for 1 cycle.
REQ-015 Cycle after acceptance: start_en pulses and input_r latches user_value.
REQ-016 Compute function: cf_return_value = input_r + 1, modulo 2^32. cf_done pulses exactly CF_LATENCY cycles after start_en; CALC then goes to EMIT.
REQ-017 In EMIT, bytes 14..17 of the held beat SHALL be replaced by cf_return_value (big-endian); all other bytes, keep, user and last are unchanged.
REQ-018 return_valid pulses and return_value = cf_return_value in the cycle the modified beat enters the output register.
REQ-019 A back-to-back trigger packet SHALL wait until the previous packet's tlast has been accepted.
REQ-020 A 32-bit trigger counter SHALL increment on each return_valid and wrap at 2^32.
REQ-021 AXI-Lite read map: 0x00 = 32'h574F4D42 ("WOMB"), 0x04 = trigger counter, any other address = 0; RRESP = OKAY.
REQ-022 AXI-Lite writes SHALL be accepted and ignored, with BRESP = OKAY.

Reset
REQ-023 While axis_reset is high, all registers clear asynchronously:
- FSM goes to IDLE;
- m_axis_tvalid, s_axis_tready, all data outputs, pulses and the counter are 0;
- AXI-Lite VALID/READY outputs are 0.
REQ-024 Reset mid-packet SHALL discard the packet in flight; the first beat after reset is treated as a new packet start.

Configuration
REQ-025 Macro WOMBAT_SWAP_MAC_EN defined: in EMIT, bytes 0..5 and bytes 6..11 of the held beat are also exchanged (reply addressing).
REQ-026 WOMBAT_SWAP_MAC_EN undefined: MAC bytes pass unchanged.

Structure
REQ-027 Shared package wombat_pkg SHALL hold:
- stream width constants 256/32/128;
- byte offsets 12/14;
- the ID constant;
- register addresses;
- the FSM state enum.
REQ-028 The compute function SHALL be the sub-module wombat_cf (ports: start_en, input_r, cf_done, cf_return_value).
REQ-029 Internal nets user_value(_valid), start_en, input_r, cf_done, cf_return_value and return_(valid|value) SHALL exist under these names for bench monitoring.

Verification
REQ-030 Reset: assert axis_reset for 20 cycles -> m_axis_tvalid=0, s_axis_tready=0; after release s_axis_tready=1 in IDLE.
REQ-031 Two-beat packet with EtherType 0x0800, m_axis_tready=1 -> both beats bit-identical on m_axis, 1 cycle later, no trigger pulses.
REQ-032 Trigger packet with value 0x00000041 -> user_value=0x00000041; cf_done 4 cycles after start_en with 0x00000042; egress bytes 14..17 = 00 00 00 42, rest unchanged; register 0x04 reads 1.
REQ-033 Trigger value 0xFFFFFFFF -> returned field 0x00000000.
REQ-034 Three trigger packets back-to-back with m_axis_tready toggling every cycle -> three ordered, complete packets out; counter = 3.
REQ-035 Build with WOMBAT_SWAP_MAC_EN, dst MAC 02:00:00:00:00:01, src MAC 02:00:00:00:00:02 -> egress dst 02:00:00:00:00:02, src 02:00:00:00:00:01.

Source files
------------

// File: rtl/wombat_pkg.sv
// wombat_pkg: stream widths, header byte offsets, register map and FSM
// state type shared by the wombat trigger/compute datapath.
package wombat_pkg;

    // AXI-Stream widths
    localparam int unsigned TDATA_W = 256;
    localparam int unsigned TKEEP_W = 32;
    localparam int unsigned TUSER_W = 128;

    // Header byte offsets within the first beat
    localparam int unsigned ETYPE_OFS = 12;
    localparam int unsigned VALUE_OFS = 14;
    localparam int unsigned MAC_BYTES = 6;

    // AXI-Lite register map
    localparam logic [31:0] ID_VALUE     = 32'h574F4D42; // "WOMB"
    localparam logic [11:0] REG_ID_ADDR  = 12'h000;
    localparam logic [11:0] REG_CNT_ADDR = 12'h004;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_CALC,
        ST_EMIT
    } state_t;

    // Big-endian 32-bit field starting at byte ofs
    function automatic logic [31:0] get_be32(input logic [TDATA_W-1:0] d,
                                             input int unsigned ofs);
        return {d[ofs*8 +: 8], d[(ofs+1)*8 +: 8],
                d[(ofs+2)*8 +: 8], d[(ofs+3)*8 +: 8]};
    endfunction

    // Read-side register decode; unmapped addresses read as zero
    function automatic logic [31:0] reg_read(input logic [11:0] addr,
                                             input logic [31:0] count);
        case (addr)
            REG_ID_ADDR:  return ID_VALUE;
            REG_CNT_ADDR: return count;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/wombat_cf.sv
// wombat_cf: compute function. Result is input_r + 1; cf_done is a
// delayed copy of start_en, arriving exactly CF_LATENCY cycles later.
module wombat_cf
    import wombat_pkg::*;
#(
    parameter int unsigned CF_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_en,
    input  logic [31:0] input_r,
    output logic        cf_done,
    output logic [31:0] cf_return_value
);

    logic [CF_LATENCY-1:0] pipe;

    // Latency shift register carrying the start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= start_en;
            for (int unsigned i = 1; i < CF_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign cf_done         = pipe[CF_LATENCY-1];
    assign cf_return_value = input_r + 32'd1;

endmodule

// File: rtl/wombat.sv
// wombat: AXI-Stream trigger-packet processor. Trigger packets (matching
// EtherType, 18+ valid bytes) have bytes 14..17 replaced by the compute
// result; all other traffic passes through one register stage.
// Optional build macro: WOMBAT_SWAP_MAC_EN swaps dst/src MAC on emitted beats.
module wombat
    import wombat_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int unsigned CF_LATENCY = 4
) (
    input  logic               axis_aclk,
    input  logic               axis_reset,
    // ingress
    input  logic [TDATA_W-1:0] s_axis_tdata,
    input  logic [TKEEP_W-1:0] s_axis_tkeep,
    input  logic [TUSER_W-1:0] s_axis_tuser,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    // egress
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic [TKEEP_W-1:0] m_axis_tkeep,
    output logic [TUSER_W-1:0] m_axis_tuser,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    // AXI-Lite status slave
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic [11:0]        S_AXI_AWADDR,
    input  logic               S_AXI_AWVALID,
    output logic               S_AXI_AWREADY,
    input  logic [31:0]        S_AXI_WDATA,
    input  logic [3:0]         S_AXI_WSTRB,
    input  logic               S_AXI_WVALID,
    output logic               S_AXI_WREADY,
    output logic [1:0]         S_AXI_BRESP,
    output logic               S_AXI_BVALID,
    input  logic               S_AXI_BREADY,
    input  logic [11:0]        S_AXI_ARADDR,
    input  logic               S_AXI_ARVALID,
    output logic               S_AXI_ARREADY,
    output logic [31:0]        S_AXI_RDATA,
    output logic [1:0]         S_AXI_RRESP,
    output logic               S_AXI_RVALID,
    input  logic               S_AXI_RREADY
);

    state_t             state;
    logic               running;
    logic [TDATA_W-1:0] held_data;
    logic [TKEEP_W-1:0] held_keep;
    logic [TUSER_W-1:0] held_user;
    logic               held_last;

    logic               out_load;
    logic               s_fire;
    logic               is_trigger;
    logic               pass_fire;
    logic [TDATA_W-1:0] mod_data;

    logic [31:0]        user_value;
    logic               user_value_valid;
    logic               start_en;
    logic [31:0]        input_r;
    logic               cf_done;
    logic [31:0]        cf_return_value;
    logic               return_valid;
    logic [31:0]        return_value;
    logic [31:0]        trig_count;

    // Write data and the alternate AXI clock/reset carry no information
    logic unused_axil;
    assign unused_axil = ^{S_AXI_ACLK, S_AXI_ARESETN, S_AXI_AWADDR,
                           S_AXI_WDATA, S_AXI_WSTRB};

    // running keeps s_axis_tready low while reset is asserted
    assign out_load      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = running && (state == ST_IDLE || state == ST_PASS)
                           && out_load;
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    assign is_trigger = (&s_axis_tkeep[17:0])
                        && (s_axis_tdata[ETYPE_OFS*8 +: 8] == ETHERTYPE[15:8])
                        && (s_axis_tdata[(ETYPE_OFS+1)*8 +: 8] == ETHERTYPE[7:0]);

    assign user_value       = get_be32(s_axis_tdata, VALUE_OFS);
    assign user_value_valid = s_fire && (state == ST_IDLE) && is_trigger;
    assign pass_fire        = s_fire && !user_value_valid;

    assign return_valid = (state == ST_EMIT) && out_load;
    assign return_value = cf_return_value;

    // Held first beat with the result patched in (big-endian)
    always_comb begin
        mod_data = held_data;
`ifdef WOMBAT_SWAP_MAC_EN
        for (int unsigned b = 0; b < MAC_BYTES; b++) begin
            mod_data[b*8 +: 8]             = held_data[(b+MAC_BYTES)*8 +: 8];
            mod_data[(b+MAC_BYTES)*8 +: 8] = held_data[b*8 +: 8];
        end
`endif
        for (int unsigned b = 0; b < 4; b++) begin
            mod_data[(VALUE_OFS+b)*8 +: 8] = cf_return_value[(3-b)*8 +: 8];
        end
    end

    // Packet FSM: tracks packet boundaries, holds trigger beats, starts compute
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            held_data <= '0;
            held_keep <= '0;
            held_user <= '0;
            held_last <= 1'b0;
            start_en  <= 1'b0;
            input_r   <= '0;
        end else begin
            running  <= 1'b1;
            start_en <= user_value_valid;
            if (user_value_valid) begin
                input_r <= user_value;
            end
            case (state)
                ST_IDLE: begin
                    if (s_fire) begin
                        if (is_trigger) begin
                            held_data <= s_axis_tdata;
                            held_keep <= s_axis_tkeep;
                            held_user <= s_axis_tuser;
                            held_last <= s_axis_tlast;
                            state     <= ST_CALC;
                        end else if (!s_axis_tlast) begin
                            state <= ST_PASS;
                        end
                    end
                end
                ST_PASS: begin
                    if (s_fire && s_axis_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cf_done) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (return_valid) begin
                        state <= held_last ? ST_IDLE : ST_PASS;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Egress register: loads a passed beat or the modified held beat
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_load) begin
            if (return_valid) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= mod_data;
                m_axis_tkeep  <= held_keep;
                m_axis_tuser  <= held_user;
                m_axis_tlast  <= held_last;
            end else if (pass_fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tuser  <= s_axis_tuser;
                m_axis_tlast  <= s_axis_tlast;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Trigger counter, one per emitted result
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            trig_count <= '0;
        end else if (return_valid) begin
            trig_count <= trig_count + 32'd1;
        end
    end

    // AXI-Lite: writes acknowledged and dropped, reads decoded from the map
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_AWREADY <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID
                             && !S_AXI_BVALID;
            S_AXI_WREADY  <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID
                             && !S_AXI_BVALID;
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end else if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                S_AXI_BVALID <= 1'b1;
            end

            S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end else if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= reg_read(S_AXI_ARADDR, trig_count);
            end
        end
    end

    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_RRESP = RESP_OKAY;

    wombat_cf #(.CF_LATENCY(CF_LATENCY)) u_cf (
        .clk             (axis_aclk),
        .rst             (axis_reset),
        .start_en        (start_en),
        .input_r         (input_r),
        .cf_done         (cf_done),
        .cf_return_value (cf_return_value)
    );

endmodule

// File: tb/tb_wombat.sv
// tb_wombat: directed, table-driven bench for wombat.
module tb_wombat;
    import wombat_pkg::*;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    typedef struct {
        logic [15:0] et;
        logic [31:0] val;
        logic [31:0] keep;
        logic        trig;
        logic [31:0] ret;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         axis_reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid, m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic [11:0]  AWADDR, ARADDR;
    logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, ARVALID, ARREADY, RVALID;
    logic [31:0]  WDATA, RDATA;
    logic [1:0]   BRESP, RRESP;

    wombat #(.ETHERTYPE(16'h88B5), .CF_LATENCY(4)) dut (
        .axis_aclk(clk), .axis_reset(axis_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(1'b1),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(1'b1),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(1'b1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_cnt = 0;
    logic tog_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Egress monitor: sets tready, then records the beat the next edge consumes
    beat_t got_q[$];
    int    mon_cyc[$];
    always @(negedge clk) begin
        if (tog_mode) m_axis_tready = ~m_axis_tready;
        else          m_axis_tready = 1'b1;
        if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
            mon_cyc.push_back(cyc + 1);
        end
    end

    // Internal-net monitor, sampled just before each rising edge
    int uv_cnt = 0, rv_cnt = 0, uv_cyc = 0, st_cyc = 0, done_cyc = 0;
    logic [31:0] uv_val = '0, done_val = '0, rv_val = '0;
    always begin
        @(negedge clk);
        #4;
        if (dut.user_value_valid) begin uv_cnt++; uv_cyc = cyc; uv_val = dut.user_value; end
        if (dut.start_en) st_cyc = cyc;
        if (dut.cf_done) begin done_cyc = cyc; done_val = dut.cf_return_value; end
        if (dut.return_valid) begin rv_cnt++; rv_val = dut.return_value; end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
        end
    endtask

    function automatic beat_t mk_beat0(int seed, logic [15:0] et, logic [31:0] val, logic [31:0] keep);
        beat_t b;
        for (int n = 0; n < 32; n++) b.data[n*8 +: 8] = 8'(seed * 37 + n * 5 + 1);
        b.data[95:0]    = {8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                           8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
        b.data[111:96]  = {et[7:0], et[15:8]};
        b.data[143:112] = {val[7:0], val[15:8], val[23:16], val[31:24]};
        b.keep = keep;
        b.user = {4{32'(seed) ^ 32'hC0DE0000}};
        b.last = 1'b0;
        return b;
    endfunction

    function automatic beat_t mk_beat1(int seed);
        beat_t b;
        for (int n = 0; n < 32; n++) b.data[n*8 +: 8] = 8'(seed * 11 + n * 3 + 128);
        b.keep = 32'h0000FFFF;
        b.user = {4{32'(seed) ^ 32'h5A5A0000}};
        b.last = 1'b1;
        return b;
    endfunction

    function automatic beat_t exp_emit(beat_t b, logic [31:0] ret);
        beat_t e = b;
        e.data[143:112] = {ret[7:0], ret[15:8], ret[23:16], ret[31:24]};
`ifdef WOMBAT_SWAP_MAC_EN
        e.data[47:0]  = b.data[95:48];
        e.data[95:48] = b.data[47:0];
`endif
        return e;
    endfunction

    // Call at a falling edge; returns at a falling edge after acceptance
    task automatic send_beat(input beat_t b, output int acc);
        bit ok = 0;
        acc = 0;
        s_axis_tdata = b.data; s_axis_tkeep = b.keep; s_axis_tuser = b.user;
        s_axis_tlast = b.last; s_axis_tvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            #4;
            if (s_axis_tready) begin ok = 1; acc = cyc + 1; break; end
            @(negedge clk);
        end
        if (!ok) check("ingress accept timeout", 0, 1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 400; k++) begin
            if (got_q.size() >= n) break;
            @(negedge clk);
        end
        if (got_q.size() < n) check("egress drain timeout", got_q.size(), n);
    endtask

    task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
        bit ok = 0;
        d = '0;
        @(negedge clk);
        ARADDR = a; ARVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #4;
            if (ARREADY) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        ARVALID = 1'b0;
        if (!ok) begin check("axil AR timeout", 0, 1); return; end
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            if (RVALID) begin d = RDATA; ok = 1; check("axil RRESP", RRESP, 2'b00); break; end
            @(negedge clk);
        end
        if (!ok) check("axil R timeout", 0, 1);
    endtask

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        bit ok = 0;
        @(negedge clk);
        AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #4;
            if (AWREADY && WREADY) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        if (!ok) begin check("axil AW timeout", 0, 1); return; end
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            if (BVALID) begin ok = 1; check("axil BRESP", BRESP, 2'b00); break; end
            @(negedge clk);
        end
        if (!ok) check("axil B timeout", 0, 1);
    endtask

    task automatic run_pkt(input vec_t v, input int idx);
        beat_t b0, b1, e0;
        int base, uv0, rv0, acc0, acc1;
        logic [31:0] rd;
        base = got_q.size(); uv0 = uv_cnt; rv0 = rv_cnt;
        b0 = mk_beat0(idx, v.et, v.val, v.keep);
        b1 = mk_beat1(idx);
        e0 = v.trig ? exp_emit(b0, v.ret) : b0;
        @(negedge clk);
        send_beat(b0, acc0);
        send_beat(b1, acc1);
        wait_beats(base + 2);
        repeat (2) @(negedge clk);
        if (got_q.size() >= base + 2) begin
            check($sformatf("pkt%0d beat0", idx), got_q[base], e0);
            check($sformatf("pkt%0d beat1", idx), got_q[base+1], b1);
            check($sformatf("pkt%0d extra beats", idx), got_q.size(), base + 2);
        end
        if (v.trig) begin
            exp_cnt++;
            check($sformatf("pkt%0d user_value pulses", idx), uv_cnt - uv0, 1);
            check($sformatf("pkt%0d user_value", idx), uv_val, v.val);
            check($sformatf("pkt%0d start_en delay", idx), st_cyc - uv_cyc, 1);
            check($sformatf("pkt%0d cf_done latency", idx), done_cyc - st_cyc, 4);
            check($sformatf("pkt%0d cf_return_value", idx), done_val, v.ret);
            check($sformatf("pkt%0d return pulses", idx), rv_cnt - rv0, 1);
            check($sformatf("pkt%0d return_value", idx), rv_val, v.ret);
        end else begin
            if (got_q.size() >= base + 2)
                check($sformatf("pkt%0d pass latency", idx), mon_cyc[base] - acc0, 1);
            check($sformatf("pkt%0d trigger pulses", idx), (uv_cnt - uv0) + (rv_cnt - rv0), 0);
        end
        axil_read(REG_CNT_ADDR, rd);
        check($sformatf("pkt%0d counter", idx), rd, exp_cnt);
    endtask

    initial begin
        vec_t tbl[7];
        beat_t exp_q[$];
        beat_t b;
        logic [31:0] rd;
        logic [31:0] bb_val [3];
        int acc, base;

        axis_reset = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tuser = '0; s_axis_tlast = 1'b0;
        AWADDR = '0; ARADDR = '0; WDATA = '0;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;

        tbl[0] = '{16'h0800, 32'h00000041, 32'hFFFFFFFF, 1'b0, 32'h00000041};
        tbl[1] = '{16'h88B5, 32'h00000041, 32'hFFFFFFFF, 1'b1, 32'h00000042};
        tbl[2] = '{16'h88B5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        tbl[3] = '{16'h88B5, 32'h00001234, 32'hFFFDFFFF, 1'b0, 32'h00001234};
        tbl[4] = '{16'h88B4, 32'h00000005, 32'hFFFFFFFF, 1'b0, 32'h00000005};
        tbl[5] = '{16'hB588, 32'h00000007, 32'hFFFFFFFF, 1'b0, 32'h00000007};
        tbl[6] = '{16'h88B5, 32'h7FFFFFFF, 32'h0003FFFF, 1'b1, 32'h80000000};

        // Reset state
        repeat (20) @(negedge clk);
        check("reset m_tvalid", m_axis_tvalid, 0);
        check("reset s_tready", s_axis_tready, 0);
        check("reset axil valid/ready", {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
        axis_reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle s_tready", s_axis_tready, 1);

        axil_read(REG_ID_ADDR, rd);  check("reg id", rd, 32'h574F4D42);
        axil_read(REG_CNT_ADDR, rd); check("reg count after reset", rd, 0);
        axil_read(12'h008, rd);      check("reg unmapped", rd, 0);

        for (int i = 0; i < 7; i++) run_pkt(tbl[i], i);

        axil_write(REG_CNT_ADDR, 32'hDEADBEEF);
        axil_read(REG_CNT_ADDR, rd); check("counter after write", rd, 3);

        // Mid-packet reset: leave a non-trigger packet open, then reset
        @(negedge clk);
        b = mk_beat0(20, 16'h0800, 32'h1, 32'hFFFFFFFF);
        send_beat(b, acc);
        axis_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid-reset m_tvalid", m_axis_tvalid, 0);
        axis_reset = 1'b0;
        repeat (2) @(negedge clk);
        axil_read(REG_CNT_ADDR, rd); check("counter after mid reset", rd, 0);

        // Back-to-back triggers under toggling egress ready
        base = got_q.size();
        tog_mode = 1'b1;
        bb_val[0] = 32'h00000010; bb_val[1] = 32'h7FFFFFFF; bb_val[2] = 32'hABCDEF00;
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            b = mk_beat0(30 + p, 16'h88B5, bb_val[p], 32'hFFFFFFFF);
            exp_q.push_back(exp_emit(b, bb_val[p] + 32'd1));
            send_beat(b, acc);
            b = mk_beat1(30 + p);
            exp_q.push_back(b);
            send_beat(b, acc);
        end
        wait_beats(base + 6);
        repeat (4) @(negedge clk);
        tog_mode = 1'b0;
        if (got_q.size() >= base + 6) begin
            for (int k = 0; k < 6; k++)
                check($sformatf("b2b beat%0d", k), got_q[base+k], exp_q[k]);
            check("b2b extra beats", got_q.size(), base + 6);
        end
        axil_read(REG_CNT_ADDR, rd); check("b2b counter", rd, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
